// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared state, request record and arbitration helper for cache_arbiter
package cache_arbiter_pkg;

   localparam int ARB_REQUESTERS = 2;
   localparam int REQ_ADDR_BITS  = 32;
   localparam int REQ_DATA_BITS  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic                     owner;
      logic                     is_write;
      logic [REQ_ADDR_BITS-1:0] address;
      logic [REQ_DATA_BITS-1:0] data;
   } req_t;

   // With a single requester present it wins outright; a tie goes to the pointer.
   function automatic logic pick_winner(input logic i_req0, input logic i_req1, input logic i_ptr);
      return (i_req0 && i_req1) ? i_ptr : i_req1;
   endfunction

endpackage

// File: rtl/cache_arb_timer.sv
// rtl/cache_arb_timer.sv - BUSY-cycle watchdog counter, built only with CACHE_ARB_TIMEOUT_EN
module cache_arb_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Fires during the TIMEOUT_CYCLES-th enabled cycle so the owner leaves BUSY at its end.
   assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-requester round-robin cache port arbiter; optional watchdog via CACHE_ARB_TIMEOUT_EN
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int RAM_ADDRESS_BITS = REQ_ADDR_BITS,
   parameter int DATA_BITS        = REQ_DATA_BITS,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [RAM_ADDRESS_BITS-1:0] r0_address,
   input  logic                        r0_read_en,
   input  logic                        r0_write_en,
   input  logic [DATA_BITS-1:0]        r0_write_data,
   output logic [DATA_BITS-1:0]        r0_read_data,
   output logic                        r0_valid,
   output logic                        r0_grant,
   input  logic [RAM_ADDRESS_BITS-1:0] r1_address,
   input  logic                        r1_read_en,
   input  logic                        r1_write_en,
   input  logic [DATA_BITS-1:0]        r1_write_data,
   output logic [DATA_BITS-1:0]        r1_read_data,
   output logic                        r1_valid,
   output logic                        r1_grant,
   output logic [RAM_ADDRESS_BITS-1:0] c_address,
   output logic                        c_read_en,
   output logic                        c_write_en,
   output logic [DATA_BITS-1:0]        c_write_data,
   input  logic [DATA_BITS-1:0]        c_read_data,
   input  logic                        c_valid,
   input  logic                        c_miss,
   output logic                        busy,
   output logic                        err
);

   state_t               r_state;
   state_t               w_next_state;
   req_t                 r_req;
   logic                 r_ptr;
   logic [DATA_BITS-1:0] r_read_data [ARB_REQUESTERS];
   logic                 w_req0;
   logic                 w_req1;
   logic                 w_winner;
   logic                 w_abort;

   assign w_req0   = r0_read_en | r0_write_en;
   assign w_req1   = r1_read_en | r1_write_en;
   assign w_winner = pick_winner(w_req0, w_req1, r_ptr);

`ifdef CACHE_ARB_TIMEOUT_EN
   logic r_err;
   logic w_timeout;

   cache_arb_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (r_state != BUSY),
      .i_enable  (r_state == BUSY),
      .o_expired (w_timeout)
   );

   assign w_abort = w_timeout;
   assign err     = r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (r_state == BUSY && !c_valid && w_timeout) begin
         r_err <= 1'b1;
      end
   end
`else
   assign w_abort = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // c_miss deliberately plays no part: a refill simply keeps us in BUSY.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_req0 || w_req1) w_next_state = BUSY;
         BUSY:    if (c_valid || w_abort) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req          <= '0;
         r_ptr          <= 1'b0;
         r_read_data[0] <= '0;
         r_read_data[1] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req0 || w_req1) begin
                  r_req.owner    <= w_winner;
                  r_req.is_write <= w_winner ? r1_write_en : r0_write_en;
                  r_req.address  <= REQ_ADDR_BITS'(w_winner ? r1_address : r0_address);
                  r_req.data     <= REQ_DATA_BITS'(w_winner ? r1_write_data : r0_write_data);
               end
            end
            BUSY: begin
               if (c_valid) begin
                  r_read_data[r_req.owner] <= c_read_data;
               end else if (w_abort) begin
                  r_read_data[r_req.owner] <= '0;
               end
            end
            DONE:    r_ptr <= ~r_req.owner;
            default: ;
         endcase
      end
   end

   always_comb begin
      c_address    = '0;
      c_read_en    = 1'b0;
      c_write_en   = 1'b0;
      c_write_data = '0;
      r0_grant     = 1'b0;
      r1_grant     = 1'b0;
      r0_valid     = 1'b0;
      r1_valid     = 1'b0;
      busy         = 1'b0;
      case (r_state)
         BUSY: begin
            busy         = 1'b1;
            c_address    = RAM_ADDRESS_BITS'(r_req.address);
            c_read_en    = !r_req.is_write;
            c_write_en   = r_req.is_write;
            c_write_data = DATA_BITS'(r_req.data);
            r0_grant     = !r_req.owner;
            r1_grant     = r_req.owner;
         end
         DONE: begin
            r0_valid = !r_req.owner;
            r1_valid = r_req.owner;
         end
         default: ;
      endcase
   end

   assign r0_read_data = r_read_data[0];
   assign r1_read_data = r_read_data[1];

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter (vector table, corner sequences, randomized traffic)
`timescale 1ns/1ps
module tb_cache_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] r0_address, r1_address, c_address;
   logic          r0_read_en, r0_write_en, r1_read_en, r1_write_en;
   logic [DW-1:0] r0_write_data, r1_write_data, r0_read_data, r1_read_data;
   logic          r0_valid, r1_valid, r0_grant, r1_grant;
   logic          c_read_en, c_write_en, c_valid, c_miss, busy, err;
   logic [DW-1:0] c_write_data, c_read_data;

   cache_arbiter #(
      .RAM_ADDRESS_BITS (AW),
      .DATA_BITS        (DW),
      .TIMEOUT_CYCLES   (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .r0_address    (r0_address),
      .r0_read_en    (r0_read_en),
      .r0_write_en   (r0_write_en),
      .r0_write_data (r0_write_data),
      .r0_read_data  (r0_read_data),
      .r0_valid      (r0_valid),
      .r0_grant      (r0_grant),
      .r1_address    (r1_address),
      .r1_read_en    (r1_read_en),
      .r1_write_en   (r1_write_en),
      .r1_write_data (r1_write_data),
      .r1_read_data  (r1_read_data),
      .r1_valid      (r1_valid),
      .r1_grant      (r1_grant),
      .c_address     (c_address),
      .c_read_en     (c_read_en),
      .c_write_en    (c_write_en),
      .c_write_data  (c_write_data),
      .c_read_data   (c_read_data),
      .c_valid       (c_valid),
      .c_miss        (c_miss),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   int            n_pass  = 0;
   int            n_total = 0;
   bit            m_ptr;
   logic [DW-1:0] m_rd [2];

   typedef struct {
      bit            rd0, wr0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      bit            rd1, wr1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      int            delay;
      logic [DW-1:0] rdata;
      bit            drop_all;
      int            exp_owner;
      bit            exp_write;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      r0_address = '0; r0_read_en = 0; r0_write_en = 0; r0_write_data = '0;
      r1_address = '0; r1_read_en = 0; r1_write_en = 0; r1_write_data = '0;
      c_read_data = '0; c_valid = 0; c_miss = 0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctl"}, {c_read_en, c_write_en, busy, r0_grant, r1_grant, r0_valid, r1_valid}, 0);
      chk({name, "_caddr"}, c_address, 0);
      chk({name, "_cwdata"}, c_write_data, 0);
   endtask

   // Requests are already driven and the DUT is in IDLE: the next edge samples them.
   task automatic serve(input int owner, input bit we, input int delay,
                        input logic [DW-1:0] rdata, input bit drop_all);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = (owner != 0) ? r1_address : r0_address;
      d = (owner != 0) ? r1_write_data : r0_write_data;
      step();
      for (int i = 0; i <= delay; i++) begin
         chk("busy", busy, 1);
         chk("grant", {r1_grant, r0_grant}, (owner != 0) ? 2'b10 : 2'b01);
         chk("c_address", c_address, a);
         chk("c_write_en", c_write_en, we);
         chk("c_read_en", c_read_en, !we);
         if (we) chk("c_write_data", c_write_data, d);
         chk("busy_valid", {r1_valid, r0_valid}, 0);
         r0_address = $urandom; r1_address = $urandom;
         r0_write_data = $urandom; r1_write_data = $urandom;
         if (i < delay) begin
            c_miss = 1;
         end else begin
            c_miss = 0; c_valid = 1; c_read_data = rdata;
         end
         step();
      end
      c_valid = 0;
      c_read_data = $urandom;
      if (owner == 0 || drop_all) begin r0_read_en = 0; r0_write_en = 0; end
      if (owner == 1 || drop_all) begin r1_read_en = 0; r1_write_en = 0; end
      m_rd[owner] = rdata;
      m_ptr = (owner == 0);
      chk("done_valid", {r1_valid, r0_valid}, (owner != 0) ? 2'b10 : 2'b01);
      chk("done_rd0", r0_read_data, m_rd[0]);
      chk("done_rd1", r1_read_data, m_rd[1]);
      chk("done_ctl", {c_read_en, c_write_en, busy, r0_grant, r1_grant}, 0);
      step();
      chk("idle_ctl", {r1_valid, r0_valid, busy}, 0);
      chk("idle_rd0", r0_read_data, m_rd[0]);
      chk("idle_rd1", r1_read_data, m_rd[1]);
   endtask

   initial begin
      vecs[0] = '{1,0,32'h10000,0,   0,0,0,0,          0, 32'h20, 1, 0, 0};
      vecs[1] = '{0,0,0,0,           0,1,32'h5001,32'hFAFA, 5, 32'h77, 1, 1, 1};
      vecs[2] = '{1,0,32'h100,0,     1,0,32'h200,0,    1, 32'h31, 0, 0, 0};
      vecs[3] = '{0,0,0,0,           1,0,32'h200,0,    0, 32'h32, 1, 1, 0};
      vecs[4] = '{1,1,32'h44,32'hDEAD, 1,0,32'h300,0,  2, 32'h55, 0, 0, 1};
      vecs[5] = '{1,0,32'h48,0,      1,0,32'h300,0,    0, 32'h66, 0, 1, 0};
      vecs[6] = '{1,0,32'h48,0,      1,1,32'h304,32'hBEEF, 0, 32'h99, 1, 0, 0};
      vecs[7] = '{0,0,0,0,           1,1,32'h304,32'hBEEF, 3, 32'h12, 1, 1, 1};

      quiet_inputs();
      m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0;
      reset_n = 0;
      step(); step();
      chk_all_zero("reset");
      chk("reset_rd", {r0_read_data, r1_read_data}, 0);
      chk("reset_err", err, 0);
      @(negedge clk) reset_n = 1;
      step();
      chk_all_zero("post_reset");

      foreach (vecs[k]) begin
         r0_read_en = vecs[k].rd0; r0_write_en = vecs[k].wr0;
         r0_address = vecs[k].a0;  r0_write_data = vecs[k].d0;
         r1_read_en = vecs[k].rd1; r1_write_en = vecs[k].wr1;
         r1_address = vecs[k].a1;  r1_write_data = vecs[k].d1;
         serve(vecs[k].exp_owner, vecs[k].exp_write, vecs[k].delay, vecs[k].rdata, vecs[k].drop_all);
      end

      quiet_inputs();
      c_valid = 1; c_read_data = 32'hBAD;
      step();
      c_valid = 0;
      chk("stray_cvalid", {r1_valid, r0_valid, busy}, 0);
      step();
      chk("stray_rd0", r0_read_data, m_rd[0]);
      chk("stray_rd1", r1_read_data, m_rd[1]);

`ifdef CACHE_ARB_TIMEOUT_EN
      r0_read_en = 1; r0_address = 32'hABC;
      step();
      for (int i = 0; i < 8; i++) begin
         chk("to_busy", busy, 1);
         chk("to_err_low", err, 0);
         step();
      end
      r0_read_en = 0;
      m_rd[0] = '0; m_ptr = 1;
      chk("to_valid", {r1_valid, r0_valid}, 2'b01);
      chk("to_rdata", r0_read_data, 0);
      chk("to_err", err, 1);
      chk("to_ctl", {c_read_en, c_write_en, busy}, 0);
      step();
      chk("to_err_sticky", err, 1);
      r1_read_en = 1; r1_address = 32'h7000;
      serve(1, 0, 0, 32'h5A, 1);
      chk("to_err_after", err, 1);
`else
      r0_read_en = 1; r0_address = 32'hABC;
      serve(int'(m_ptr & 1'b0), 0, 20, 32'hC3, 1);
      chk("stall_err", err, 0);
`endif

      r0_read_en = 1; r0_address = 32'h1234;
      step();
      chk("rst_busy_pre", busy, 1);
      #2 reset_n = 0;
      #1;
      chk_all_zero("rst_busy");
      chk("rst_busy_rd", {r0_read_data, r1_read_data}, 0);
      chk("rst_busy_err", err, 0);
      m_rd[0] = '0; m_rd[1] = '0; m_ptr = 0;
      r0_read_en = 0;
      r1_read_en = 1; r1_address = 32'h2000;
      @(negedge clk) reset_n = 1;
      serve(1, 0, 1, 32'hC0, 1);
      r0_read_en = 1; r0_address = 32'h3000;
      r1_read_en = 1; r1_address = 32'h3004;
      serve(0, 0, 0, 32'hC1, 1);

      for (int it = 0; it < 40; it++) begin
         bit       p0, p1;
         bit [1:0] op0, op1;
         int       w;
         bit       we;
         p0 = 1'($urandom_range(0, 1));
         p1 = 1'($urandom_range(0, 1));
         if (!p0 && !p1) p0 = 1;
         op0 = 2'($urandom_range(1, 3));
         op1 = 2'($urandom_range(1, 3));
         r0_read_en = p0 & op0[0]; r0_write_en = p0 & op0[1];
         r1_read_en = p1 & op1[0]; r1_write_en = p1 & op1[1];
         r0_address = $urandom; r0_write_data = $urandom;
         r1_address = $urandom; r1_write_data = $urandom;
         w  = (p0 && p1) ? int'(m_ptr) : (p1 ? 1 : 0);
         we = (w == 1) ? r1_write_en : r0_write_en;
         serve(w, we, $urandom_range(0, 3), $urandom, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
